writeback_arbiter: RTL and testbench

//   Single-write-port arbiter feeding the register file's write port (writeReg/writeData/regWriteEnable).

---
 rtl/writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Single register-file write port shared by the ALU stream and
//               an in-order FIFO of long-latency results, with pending-write
//               lookup for decode hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    output logic                          alu_stall,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [ADDR_W-1:0]             lsu_rd,
    input  logic [DATA_W-1:0]             lsu_data,
    input  logic [ADDR_W-1:0]             query_rs1,
    input  logic [ADDR_W-1:0]             query_rs2,
    output logic                          pending_rs1,
    output logic                          pending_rs2,
    output logic                          regWriteEnable,
    output logic [ADDR_W-1:0]             writeReg,
    output logic [DATA_W-1:0]             writeData,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0]  r_rdMem   [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_dataMem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starveCnt;

    logic               w_nonEmpty;
    logic               w_force;
    logic               w_aluReq;
    logic               w_aluWrite;
    logic               w_pop;
    logic               w_accept;
    logic               w_store;
    logic [c_PTR_W-1:0] w_off;
    logic               w_hit1;
    logic               w_hit2;

    assign w_nonEmpty = (r_count != '0);
    assign w_force    = w_nonEmpty && (r_starveCnt == c_STV_W'(STARVE_LIMIT));
    assign w_aluReq   = alu_valid && (alu_rd != '0);
    assign w_aluWrite = w_aluReq && !w_force;
    assign w_pop      = w_nonEmpty && !w_aluWrite;

    // Ready looks only at the registered count, so there is no path from valid to ready.
    assign lsu_ready  = (r_count < c_CNT_W'(FIFO_DEPTH));
    assign w_accept   = lsu_valid && lsu_ready;
    assign w_store    = w_accept && (lsu_rd != '0);

    assign alu_stall  = w_force && w_aluReq;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_rdMem[r_wrPtr]   <= lsu_rd;
            r_dataMem[r_wrPtr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts consecutive cycles the head has lost to the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starveCnt <= '0;
        end else if (!w_nonEmpty || w_pop) begin
            r_starveCnt <= '0;
        end else if (r_starveCnt != c_STV_W'(STARVE_LIMIT)) begin
            r_starveCnt <= r_starveCnt + c_STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWriteEnable <= 1'b0;
            writeReg       <= '0;
            writeData      <= '0;
        end else if (w_aluWrite) begin
            regWriteEnable <= 1'b1;
            writeReg       <= alu_rd;
            writeData      <= alu_data;
        end else if (w_pop) begin
            regWriteEnable <= 1'b1;
            writeReg       <= r_rdMem[r_rdPtr];
            writeData      <= r_dataMem[r_rdPtr];
        end else begin
            regWriteEnable <= 1'b0;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_off  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = c_PTR_W'(i) - r_rdPtr;
            if ({1'b0, w_off} < r_count) begin
                if (r_rdMem[i] == query_rs1) w_hit1 = 1'b1;
                if (r_rdMem[i] == query_rs2) w_hit2 = 1'b1;
            end
        end
    end

    assign pending_rs1 = (query_rs1 != '0) &&
                         (w_hit1 || (regWriteEnable && (writeReg == query_rs1)));
    assign pending_rs2 = (query_rs2 != '0) &&
                         (w_hit2 || (regWriteEnable && (writeReg == query_rs2)));

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed scoreboard bench for writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_stall;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic [AW-1:0] query_rs1 = '0;
    logic [AW-1:0] query_rs2 = '0;
    logic          pending_rs1;
    logic          pending_rs2;
    logic          regWriteEnable;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic [2:0]    fifo_count;

    int total = 0;
    int bad = 0;
    logic [AW+DW-1:0] expQ[$];

    writeback_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .pending_rs1(pending_rs1), .pending_rs2(pending_rs2),
        .regWriteEnable(regWriteEnable), .writeReg(writeReg), .writeData(writeData),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Monitor: every write seen on the port must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (rst && regWriteEnable) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got x%0d=%h, required no write", writeReg, writeData);
            end else begin
                e = expQ.pop_front();
                if ({writeReg, writeData} !== e) begin
                    bad++;
                    $display("FAIL write_port: got x%0d=%h, required x%0d=%h",
                             writeReg, writeData, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        expQ.push_back({rd, d});
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle();
        tick(); tick();
        chk("rst_we", 64'(regWriteEnable), 64'd0);
        chk("rst_reg", 64'(writeReg), 64'd0);
        chk("rst_data", 64'(writeData), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(lsu_ready), 64'd1);
        chk("rst_stall", 64'(alu_stall), 64'd0);
        rst = 1'b1;
        tick();

        // 1) single ALU write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        chk("alu_we", 64'(regWriteEnable), 64'd1);
        idle(); tick();

        // 2) fill FIFO while the ALU holds the port, then drain in order
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd7, 32'h700 + k, 1'b1, AW'(k), 32'h100 + k);
            expect_wr(5'd7, 32'h700 + k);
            tick();
        end
        idle();
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(lsu_ready), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            expect_wr(AW'(k), 32'h100 + k);
            tick();
        end
        chk("drain_count", 64'(fifo_count), 64'd0);
        idle(); tick();

        // 3) starvation forces the head through
        drive(1'b1, 5'd7, 32'h7000_0000, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd7, 32'h7000_0000);
        tick();
        for (int j = 1; j <= SL; j++) begin
            drive(1'b1, 5'd7, 32'h7000_0000 + j, 1'b0, '0, '0);
            chk("stall_early", 64'(alu_stall), 64'd0);
            expect_wr(5'd7, 32'h7000_0000 + j);
            tick();
        end
        drive(1'b1, 5'd7, 32'h7000_0009, 1'b0, '0, '0);
        chk("stall_force", 64'(alu_stall), 64'd1);
        expect_wr(5'd9, 32'h99);
        tick();
        drive(1'b1, 5'd7, 32'h7000_0009, 1'b0, '0, '0);
        chk("stall_release", 64'(alu_stall), 64'd0);
        expect_wr(5'd7, 32'h7000_0009);
        tick();
        idle(); tick();

        // 4) full FIFO, simultaneous push+pop, rd=0 push
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd7, 32'h7A0 + k, 1'b1, AW'(k), 32'h400 + k);
            expect_wr(5'd7, 32'h7A0 + k);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0);
        chk("p_ready_full", 64'(lsu_ready), 64'd0);
        expect_wr(5'd1, 32'h401);
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0);
        chk("p_ready_3", 64'(lsu_ready), 64'd1);
        expect_wr(5'd2, 32'h402);
        tick();
        chk("pushpop_count", 64'(fifo_count), 64'd3);
        drive(1'b1, 5'd7, 32'h7B, 1'b1, 5'd0, 32'hBB);
        chk("rd0_ready", 64'(lsu_ready), 64'd1);
        expect_wr(5'd7, 32'h7B);
        tick();
        chk("rd0_count", 64'(fifo_count), 64'd3);
        idle();
        expect_wr(5'd3, 32'h403);
        expect_wr(5'd4, 32'h404);
        expect_wr(5'd10, 32'hA0);
        tick(); tick(); tick();
        chk("drain4_count", 64'(fifo_count), 64'd0);
        tick();

        // 5) pending scoreboard
        drive(1'b1, 5'd7, 32'h75, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd7, 32'h75);
        tick();
        query_rs1 = 5'd12; query_rs2 = 5'd0;
        drive(1'b1, 5'd7, 32'h76, 1'b0, '0, '0);
        chk("pend1_fifo", 64'(pending_rs1), 64'd1);
        chk("pend2_zero", 64'(pending_rs2), 64'd0);
        expect_wr(5'd7, 32'h76);
        tick();
        idle();
        chk("pend1_head", 64'(pending_rs1), 64'd1);
        expect_wr(5'd12, 32'hC0);
        tick();
        chk("pend1_port", 64'(pending_rs1), 64'd1);
        tick();
        chk("pend1_done", 64'(pending_rs1), 64'd0);
        query_rs1 = '0;

        // 6) reset mid-operation discards buffered results
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 5'd7, 32'h600 + k, 1'b1, AW'(20 + k), 32'h800 + k);
            if (k < 3) expect_wr(5'd7, 32'h600 + k);
            tick();
        end
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        idle();
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 64'(regWriteEnable), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_ready", 64'(lsu_ready), 64'd1);
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("post_rst_count", 64'(fifo_count), 64'd0);

        chk("exp_queue_empty", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
